// File: rtl/regfile_context_engine.sv
// regfile_context_engine
//
// Saves the architectural register file (x1..LAST_REG) to an outbound
// valid/ready stream, or restores it from an inbound valid/ready stream.
// The engine owns the register file's read and write ports while busy is
// high; the CPU core stalls for the whole transfer.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, mode           command strobe (sampled in IDLE) and direction
//                         (0 = save, 1 = restore)
//   busy, done            high outside IDLE; one-cycle completion pulse
//   rf_rs_addr/rf_rs_dout register file read port (async read data)
//   rf_rd_addr/rf_rd_din/rf_write_enable  register file write port
//   out_valid/out_ready/out_data/out_index  save stream
//   in_valid/in_ready/in_data               restore stream (index order x1..)
module regfile_context_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LAST_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_rs_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs_dout,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  output logic [DATA_WIDTH-1:0] rf_rd_din,
  output logic                  rf_write_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_READ,
    S_SAVE_SEND,
    S_LOAD_WAIT,
    S_LOAD_WRITE,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_mode;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_out_valid;
  logic                    r_in_ready;
  logic                    r_we;

  logic                    w_last;
  logic                    w_advance;
  logic [ADDR_WIDTH-1:0]   w_idx_next;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_idx_next = r_idx + FIRST_IDX;
  // A register is finished once its beat is handed off: the accepted stream
  // beat when saving, the write cycle when restoring.
  assign w_advance  = r_mode ? (r_state == S_LOAD_WRITE)
                             : (r_state == S_SAVE_SEND && out_ready);

  // All control outputs are flops so that rf_write_enable and the stream
  // handshakes cannot glitch and have no combinational path from any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= FIRST_IDX;
      r_addr      <= '0;
      r_data      <= '0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_idx  <= FIRST_IDX;
            r_addr <= FIRST_IDX;
            r_busy <= 1'b1;
            if (mode) begin
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD_WAIT;
            end else begin
              r_state    <= S_SAVE_READ;
            end
          end
        end
        S_SAVE_READ: begin
          r_data      <= rf_rs_dout;
          r_out_valid <= 1'b1;
          r_state     <= S_SAVE_SEND;
        end
        S_SAVE_SEND: begin
          if (w_advance) begin
            r_out_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= w_idx_next;
              r_addr  <= w_idx_next;
              r_state <= S_SAVE_READ;
            end
          end
        end
        S_LOAD_WAIT: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_in_ready <= 1'b0;
            r_we       <= 1'b1;
            r_state    <= S_LOAD_WRITE;
          end
        end
        S_LOAD_WRITE: begin
          r_we <= 1'b0;
          if (w_advance) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx      <= w_idx_next;
              r_addr     <= w_idx_next;
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD_WAIT;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_addr  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_addr      <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
          r_we        <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign rf_rs_addr      = r_addr;
  assign rf_rd_addr      = r_addr;
  assign rf_rd_din       = r_data;
  assign rf_write_enable = r_we;
  assign out_valid       = r_out_valid;
  assign out_data        = r_data;
  assign out_index       = r_addr;
  assign in_ready        = r_in_ready;

endmodule
